seq_divider: RTL and testbench



---
 rtl/alu_pkg.sv | 15 +
 rtl/div_step.sv | 27 ++
 rtl/seq_divider.sv | 115 +++++++++++
 tb/tb_seq_divider.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width, divider state encoding and
// the quotient returned for a zero divisor.
package alu_pkg;

  localparam int unsigned DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, and keep the difference if no borrow.
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH-1:0] w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_borrow;
  logic             w_unused_rem_msb;

  // Partial remainder is always below 2^(WIDTH-1) before the shift, so its MSB is dropped.
  assign w_unused_rem_msb = i_rem[WIDTH-1];
  assign w_shift          = {i_rem[WIDTH-2:0], i_bit};
  assign w_trial          = {1'b0, w_shift} - {1'b0, i_divisor};
  assign w_borrow         = w_trial[WIDTH];

  assign o_rem  = w_borrow ? w_shift : w_trial[WIDTH-1:0];
  assign o_qbit = ~w_borrow;

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider with valid/ready handshakes; one
// quotient bit per clock, results held in dedicated output registers.
module seq_divider
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned      CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_t       r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_divisor;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_rem_next;
  logic             w_qbit;
  logic             w_accept;
  logic [WIDTH-1:0] w_q_next;

  assign in_ready = (r_state == IDLE);
  assign w_accept = in_valid && in_ready;
  assign w_q_next = {r_q[WIDTH-2:0], w_qbit};

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .i_rem    (r_rem),
    .i_bit    (r_q[WIDTH-1]),
    .i_divisor(r_divisor),
    .o_rem    (w_rem_next),
    .o_qbit   (w_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_q         <= '0;
      r_divisor   <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_divisor <= divisor;
            if (divisor == '0) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_quotient  <= {WIDTH{DIV0_QUOTIENT[0]}};
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
            end else begin
              r_state <= BUSY;
              r_rem   <= '0;
              r_q     <= dividend;
              r_cnt   <= '0;
              r_dbz   <= 1'b0;
            end
          end
        end
        BUSY: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + 1'b1;
          // Results are published only on the final step so no partial value is ever visible.
          if (r_cnt == LAST_STEP) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_quotient  <= w_q_next;
            r_remainder <= w_rem_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios plus a random sweep
// against an arithmetic reference model (a / b, a % b, divide-by-zero rule).
module tb_seq_divider;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int vectors    = 0;
  int miscompares = 0;

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division; zero divisor gives all-ones / dividend / flag.
  function automatic void model(input int a, input int b, output int q, output int r,
                                output logic dz);
    if (b == 0) begin
      q  = 255;
      r  = a;
      dz = 1'b1;
    end else begin
      q  = a / b;
      r  = a % b;
      dz = 1'b0;
    end
  endfunction

  // Accepts one operation, waits for out_valid; lat counts edges after the accept edge.
  // With out_ready high the result retires on the next edge and rdy_after samples in_ready.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dz, output int lat, output logic rdy_after);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    step();
    in_valid = 1'b0;
    dividend = 'x;
    divisor  = 'x;
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
    rdy_after = 1'b0;
    if (!out_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL op_timeout %0d/%0d: out_valid=%b after %0d edges, required 1", a, b,
               out_valid, lat);
    end else if (out_ready) begin
      step();
      rdy_after = in_ready;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    #2;
    vectors += 4;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid: got %b, required 0", out_valid);
    end
    if (quotient !== '0) begin
      miscompares++; $display("FAIL reset_quotient: got %0d, required 0", quotient);
    end
    if (remainder !== '0) begin
      miscompares++; $display("FAIL reset_remainder: got %0d, required 0", remainder);
    end
    if (div_by_zero !== 1'b0) begin
      miscompares++; $display("FAIL reset_dbz: got %b, required 0", div_by_zero);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] q, r;
    logic dz, rdy;
    int lat;
    run_op(8'd200, 8'd7, q, r, dz, lat, rdy);
    vectors += 5;
    if (lat !== 8) begin
      miscompares++; $display("FAIL basic_latency: got %0d, required 8", lat);
    end
    if (q !== 8'd28) begin
      miscompares++; $display("FAIL basic_quotient: got %0d, required 28", q);
    end
    if (r !== 8'd4) begin
      miscompares++; $display("FAIL basic_remainder: got %0d, required 4", r);
    end
    if (dz !== 1'b0) begin
      miscompares++; $display("FAIL basic_dbz: got %b, required 0", dz);
    end
    if (rdy !== 1'b1) begin
      miscompares++; $display("FAIL basic_in_ready_after: got %b, required 1", rdy);
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] av[4] = '{8'd255, 8'd5, 8'd0, 8'd255};
    logic [W-1:0] bv[4] = '{8'd1, 8'd9, 8'd3, 8'd255};
    logic [W-1:0] qv[4] = '{8'd255, 8'd0, 8'd0, 8'd1};
    logic [W-1:0] rv[4] = '{8'd0, 8'd5, 8'd0, 8'd0};
    logic [W-1:0] q, r;
    logic dz, rdy;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(av[i], bv[i], q, r, dz, lat, rdy);
      vectors += 3;
      if (q !== qv[i] || r !== rv[i]) begin
        miscompares++;
        $display("FAIL boundary_result %0d/%0d: got q=%0d r=%0d, required q=%0d r=%0d",
                 av[i], bv[i], q, r, qv[i], rv[i]);
      end
      if (lat !== 8) begin
        miscompares++; $display("FAIL boundary_latency %0d/%0d: got %0d, required 8",
                                av[i], bv[i], lat);
      end
      if (dz !== 1'b0) begin
        miscompares++; $display("FAIL boundary_dbz %0d/%0d: got %b, required 0",
                                av[i], bv[i], dz);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] q, r;
    logic dz, rdy;
    int lat;
    run_op(8'd77, 8'd0, q, r, dz, lat, rdy);
    vectors += 4;
    if (lat !== 0) begin
      miscompares++; $display("FAIL div0_latency: got %0d edges, required 0", lat);
    end
    if (q !== 8'd255 || r !== 8'd77) begin
      miscompares++; $display("FAIL div0_result: got q=%0d r=%0d, required q=255 r=77", q, r);
    end
    if (dz !== 1'b1) begin
      miscompares++; $display("FAIL div0_dbz: got %b, required 1", dz);
    end
    if (rdy !== 1'b1) begin
      miscompares++; $display("FAIL div0_in_ready_after: got %b, required 1", rdy);
    end
    run_op(8'd10, 8'd3, q, r, dz, lat, rdy);
    vectors += 2;
    if (q !== 8'd3 || r !== 8'd1) begin
      miscompares++; $display("FAIL div0_follow_result: got q=%0d r=%0d, required q=3 r=1",
                              q, r);
    end
    if (dz !== 1'b0) begin
      miscompares++; $display("FAIL div0_follow_dbz: got %b, required 0", dz);
    end
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    dividend  = 8'd100;
    divisor   = 8'd9;
    step();
    // Competing requests held throughout BUSY and DONE must be ignored.
    dividend = 8'd200;
    divisor  = 8'd3;
    n = 0;
    while (!out_valid && n < 40) begin
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++; $display("FAIL bp_busy_in_ready: got %b, required 0", in_ready);
      end
      step();
      n++;
    end
    vectors++;
    if (n !== 8) begin
      miscompares++; $display("FAIL bp_latency: got %0d, required 8", n);
    end
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 8'd11 ||
          remainder !== 8'd1 || div_by_zero !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d: got v=%b rdy=%b q=%0d r=%0d dz=%b, required 1 0 11 1 0",
                 c, out_valid, in_ready, quotient, remainder, div_by_zero);
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 8'd11) begin
      miscompares++;
      $display("FAIL bp_retire: got v=%b rdy=%b q=%0d, required v=0 rdy=1 q=11",
               out_valid, in_ready, quotient);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] q, r;
    logic dz, rdy, seen;
    int lat;
    in_valid = 1'b1;
    dividend = 8'd150;
    divisor  = 8'd4;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got v=%b q=%0d r=%0d dz=%b, required all 0",
               out_valid, quotient, remainder, div_by_zero);
    end
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      step();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++; $display("FAIL midreset_no_valid: got out_valid rise, required none");
    end
    run_op(8'd150, 8'd4, q, r, dz, lat, rdy);
    vectors++;
    if (q !== 8'd37 || r !== 8'd2 || dz !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_rerun: got q=%0d r=%0d dz=%b, required q=37 r=2 dz=0", q, r, dz);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, q, r;
    logic dz, rdy, edz;
    int lat, eq, er, elat;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, 255));
      model(int'(a), int'(b), eq, er, edz);
      elat = (b == '0) ? 0 : 8;
      run_op(a, b, q, r, dz, lat, rdy);
      vectors += 3;
      if (q !== W'(eq) || r !== W'(er) || dz !== edz) begin
        miscompares++;
        $display("FAIL rand_result %0d/%0d: got q=%0d r=%0d dz=%b, required q=%0d r=%0d dz=%b",
                 a, b, q, r, dz, eq, er, edz);
      end
      if (lat !== elat) begin
        miscompares++;
        $display("FAIL rand_latency %0d/%0d: got %0d, required %0d", a, b, lat, elat);
      end
      if (!edz && !((int'(q) * int'(b) + int'(r) == int'(a)) && (r < b))) begin
        miscompares++;
        $display("FAIL rand_invariant %0d/%0d: got q=%0d r=%0d, required a==q*b+r, r<b",
                 a, b, q, r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
